// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   state_e      - controller states (IDLE, CALC, DONE), 2-bit encoding
//   MIN_CNT_W    - narrowest counter the controller will ever build
//   cnt_width()  - counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MIN_CNT_W = 1;

    // The counter runs 0 .. n-1, so $clog2(n) bits are enough.
    // The clamp keeps a legal 1-bit vector if n is ever as small as 1.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < MIN_CNT_W) ? MIN_CNT_W : w;
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor cell: computes a - b - bin.
//
// Ports:
//   a    in  : minuend bit
//   b    in  : subtrahend bit
//   bin  in  : borrow in
//   diff out : difference bit
//   bout out : borrow out
module FS_rtl (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a
    // borrow is already pending from the bit below.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_rtl.sv
// Bit-serial subtractor: out_diff = (in_a - in_b) mod 2^nbits, one bit per
// clock, LSB first, through a single FS_rtl cell.
//
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous, active-high reset
//   in_val     in  : operand pair valid
//   in_rdy     out : ready to accept operands (IDLE and not in reset)
//   in_a       in  : minuend   [nbits-1:0]
//   in_b       in  : subtrahend [nbits-1:0]
//   out_val    out : result valid (DONE)
//   out_rdy    in  : consumer accepts result
//   out_diff   out : difference [nbits-1:0]
//   out_borrow out : final borrow, 1 iff in_a < in_b (unsigned)
//
// Latency: accept edge, then nbits CALC cycles, then DONE until out_rdy.
module serial_sub_rtl
    import serial_sub_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_a,
    input  logic [nbits-1:0] in_b,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_diff,
    output logic             out_borrow
);

    localparam int CW = cnt_width(nbits);
    localparam logic [CW-1:0] LAST_BIT = CW'(nbits - 1);

    state_e           state_q,  state_d;
    logic [nbits-1:0] a_q,      a_d;
    logic [nbits-1:0] b_q,      b_d;
    logic [nbits-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic             fs_diff;
    logic             fs_bout;
    logic             accept;

    FS_rtl u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    // Handshake flags depend only on state (and reset), never on in_*,
    // so there is no combinational in->out path.
    assign in_rdy     = (state_q == IDLE) && !reset;
    assign out_val    = (state_q == DONE);
    assign out_diff   = diff_q;
    assign out_borrow = borrow_q;

    assign accept = in_val && in_rdy;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end

            CALC: begin
                // Result bits enter at the MSB; after nbits shifts the first
                // computed bit (the LSB) has reached diff_q[0].
                diff_d   = {fs_diff, diff_q[nbits-1:1]};
                a_d      = {1'b0, a_q[nbits-1:1]};
                b_d      = {1'b0, b_q[nbits-1:1]};
                borrow_d = fs_bout;
                if (cnt_q == LAST_BIT) begin
                    // Hold the counter at its last value rather than
                    // wrapping; it is cleared again on the next accept.
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
